// File: rtl/mac_datapath.sv
// Multiply-accumulate datapath: operand fetch by counter address, A*B product, accumulator and
// registered result. Define MAC_SATURATE_EN to pin ACC at all-ones on overflow instead of wrapping.
module mac_datapath #(
  parameter int DW = 8,
  parameter int CW = 4,
  parameter int AW = 2*DW+CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_a,
  input  logic          ld_b,
  input  logic          ld_m,
  input  logic          ld_acc,
  input  logic          ld_out,
  input  logic          count_enb,
  input  logic          count_reset,
  input  logic [CW-1:0] len,
  input  logic [DW-1:0] a_in,
  input  logic [DW-1:0] b_in,
  output logic [CW-1:0] addr,
  output logic          CMP,
  output logic [AW-1:0] mac_out,
  output logic          ovf_out
);
  localparam int MW = 2*DW;

  // The controller strobes are plain one-cycle enables: no valid/ready, every ld_* acts on the
  // edge at which it is high, and all of them read register values from before that edge.

  logic [DW-1:0] a_q, a_d, b_q, b_d;
  logic [MW-1:0] m_q, m_d;
  logic [AW-1:0] acc_q, acc_d, mac_out_q, mac_out_d, acc_sum;
  logic [CW-1:0] cnt_q, cnt_d, len_q, len_d, len_eff;
  logic          ovf_q, ovf_d, ovf_out_q, ovf_out_d;
  logic          first_term;
  logic [AW:0]   sum;

  always_comb begin
    first_term = count_enb && (cnt_q == '0);
    len_eff    = first_term ? len : len_q;

    a_d = ld_a ? a_in : a_q;
    b_d = ld_b ? b_in : b_q;
    m_d = m_q;
    if (ld_m) m_d = MW'(a_q) * MW'(b_q);

    // One extra bit on the sum exposes the carry out of the accumulator.
    sum = {1'b0, acc_q} + (AW+1)'(m_q);
`ifdef MAC_SATURATE_EN
    acc_sum = sum[AW] ? '1 : sum[AW-1:0];
`else
    acc_sum = sum[AW-1:0];
`endif

    acc_d = acc_q;
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    len_d = len_q;
    if (count_reset) begin
      acc_d = '0;
      ovf_d = 1'b0;
      cnt_d = '0;
    end else begin
      if (ld_acc) begin
        acc_d = acc_sum;
        if (sum[AW]) ovf_d = 1'b1;
      end
      if (count_enb && (cnt_q != '1)) cnt_d = cnt_q + CW'(1);
      if (first_term) len_d = len;
    end

    mac_out_d = ld_out ? acc_q : mac_out_q;
    ovf_out_d = ld_out ? ovf_q : ovf_out_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      m_q       <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
      len_q     <= '0;
      mac_out_q <= '0;
      ovf_out_q <= 1'b0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      mac_out_q <= mac_out_d;
      ovf_out_q <= ovf_out_d;
    end
  end

  assign addr    = cnt_q;
  assign CMP     = (cnt_q < len_eff);
  assign mac_out = mac_out_q;
  assign ovf_out = ovf_out_q;
endmodule

// File: tb/tb_mac_datapath.sv
// Directed bench for mac_datapath: a default-width instance (AW=20) and a narrow one (AW=16) share
// the controller strobes; expected values are hand-computed per step.
module tb_mac_datapath;
  logic        clk = 1'b0;
  logic        rst, ld_a, ld_b, ld_m, ld_acc, ld_out, count_enb, count_reset;
  logic [3:0]  len;
  logic [7:0]  a_in, b_in;
  logic [3:0]  addr, addr16;
  logic        cmp, cmp16;
  logic [19:0] mac_out;
  logic [15:0] mac_out16;
  logic        ovf_out, ovf_out16;

  logic [7:0] a_mem [16];
  logic [7:0] b_mem [16];

  int n_vec = 0;
  int n_err = 0;

  assign a_in = a_mem[addr];
  assign b_in = b_mem[addr];

  mac_datapath dut (
    .clk(clk), .rst(rst), .ld_a(ld_a), .ld_b(ld_b), .ld_m(ld_m), .ld_acc(ld_acc),
    .ld_out(ld_out), .count_enb(count_enb), .count_reset(count_reset), .len(len),
    .a_in(a_in), .b_in(b_in), .addr(addr), .CMP(cmp), .mac_out(mac_out), .ovf_out(ovf_out)
  );

  mac_datapath #(.DW(8), .CW(4), .AW(16)) dut16 (
    .clk(clk), .rst(rst), .ld_a(ld_a), .ld_b(ld_b), .ld_m(ld_m), .ld_acc(ld_acc),
    .ld_out(ld_out), .count_enb(count_enb), .count_reset(count_reset), .len(len),
    .a_in(a_in), .b_in(b_in), .addr(addr16), .CMP(cmp16), .mac_out(mac_out16),
    .ovf_out(ovf_out16)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic idle();
    ld_a = 0; ld_b = 0; ld_m = 0; ld_acc = 0; ld_out = 0;
    count_enb = 0; count_reset = 0;
  endtask

  task automatic clr();
    count_reset = 1; tick(); count_reset = 0;
  endtask

  task automatic do_term();
    ld_a = 1; ld_b = 1; count_enb = 1; tick();
    ld_a = 0; ld_b = 0; count_enb = 0;
    ld_m = 1; tick(); ld_m = 0;
    ld_acc = 1; tick(); ld_acc = 0;
  endtask

  task automatic do_out();
    ld_out = 1; tick(); ld_out = 0;
  endtask

  task automatic fill(input logic [7:0] a, input logic [7:0] b);
    for (int i = 0; i < 16; i++) begin
      a_mem[i] = a;
      b_mem[i] = b;
    end
  endtask

  initial begin
    idle();
    len = 0;
    fill(8'd0, 8'd0);
    rst = 1;
    tick(); tick();
    rst = 0;

    chk("reset_addr", 32'(addr), 0);
    chk("reset_cmp", 32'(cmp), 0);
    chk("reset_mac_out", 32'(mac_out), 0);
    chk("reset_ovf_out", 32'(ovf_out), 0);

    // 1*4 + 2*5 + 3*6 = 32
    a_mem[0] = 1; a_mem[1] = 2; a_mem[2] = 3;
    b_mem[0] = 4; b_mem[1] = 5; b_mem[2] = 6;
    len = 3;
    ld_a = 1; ld_b = 1; count_enb = 1; #1;
    chk("cmp_first_len3", 32'(cmp), 1);
    idle();
    do_term(); chk("cmp_term1", 32'(cmp), 1);
    do_term(); chk("cmp_term2", 32'(cmp), 1);
    do_term(); chk("cmp_term3", 32'(cmp), 0);
    do_out();
    chk("sum3_mac_out", 32'(mac_out), 32);
    chk("sum3_ovf_out", 32'(ovf_out), 0);

    // len=0 is a single term: 7*9 = 63
    clr();
    a_mem[0] = 7; b_mem[0] = 9;
    len = 0;
    ld_a = 1; ld_b = 1; count_enb = 1; #1;
    chk("cmp_first_len0", 32'(cmp), 0);
    idle();
    do_term();
    chk("len0_cmp", 32'(cmp), 0);
    chk("len0_addr", 32'(addr), 1);
    do_out();
    chk("len0_mac_out", 32'(mac_out), 63);

    // 15 * 255*255 = 975375, counter saturates at 15
    clr();
    fill(8'd255, 8'd255);
    len = 15;
    for (int i = 0; i < 14; i++) do_term();
    chk("len15_cmp14", 32'(cmp), 1);
    chk("len15_addr14", 32'(addr), 14);
    do_term();
    chk("len15_cmp15", 32'(cmp), 0);
    chk("len15_addr15", 32'(addr), 15);
    count_enb = 1; tick(); count_enb = 0;
    chk("cnt_no_wrap", 32'(addr), 15);
    do_out();
    chk("len15_mac_out", 32'(mac_out), 975375);
    chk("len15_ovf_out", 32'(ovf_out), 0);

    // 2 * 65025 = 130050 overflows a 16-bit accumulator
    clr();
    len = 2;
    do_term(); do_term();
    do_out();
    chk("len2_mac_out_aw20", 32'(mac_out), 130050);
    chk("len2_ovf_out_aw20", 32'(ovf_out), 0);
`ifdef MAC_SATURATE_EN
    chk("len2_mac_out_aw16", 32'(mac_out16), 65535);
`else
    chk("len2_mac_out_aw16", 32'(mac_out16), 64514);
`endif
    chk("len2_ovf_out_aw16", 32'(ovf_out16), 1);

    // ld_out with count_reset captures the old ACC, then starts over from zero
    clr();
    fill(8'd0, 8'd0);
    a_mem[0] = 1; a_mem[1] = 2; a_mem[2] = 3;
    b_mem[0] = 4; b_mem[1] = 5; b_mem[2] = 6;
    len = 3;
    do_term(); do_term(); do_term();
    ld_out = 1; count_reset = 1; tick(); idle();
    chk("outclr_mac_out", 32'(mac_out), 32);
    chk("outclr_addr", 32'(addr), 0);
    chk("outclr_ovf16", 32'(ovf_out16), 0);
    do_out();
    chk("outclr_acc_zero", 32'(mac_out), 0);
    a_mem[0] = 7; b_mem[0] = 9;
    len = 0;
    do_term();
    do_out();
    chk("outclr_restart", 32'(mac_out), 63);

    // rst mid-accumulate: 1*2 + 2*4 = 10 with cnt=2
    clr();
    a_mem[0] = 1; a_mem[1] = 2;
    b_mem[0] = 2; b_mem[1] = 4;
    len = 3;
    do_term(); do_term();
    do_out();
    chk("mid_mac_out", 32'(mac_out), 10);
    chk("mid_addr", 32'(addr), 2);
    rst = 1; tick(); rst = 0;
    chk("rst_mac_out", 32'(mac_out), 0);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_cmp", 32'(cmp), 0);
    do_out();
    chk("rst_acc_zero", 32'(mac_out), 0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
